// File: rtl/irq_vectorer_pkg.sv
// Shared definitions for the irq_vectorer vectored interrupt controller:
// controller states, register offsets inside the 4-byte I/O window, the
// low nibble returned for a spurious acknowledge, and the vector builder.
package irq_vectorer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        ACK      = 2'd2,
        WAIT_EOI = 2'd3
    } state_e;

    localparam logic [1:0] REG_MASK  = 2'd0;
    localparam logic [1:0] REG_PEND  = 2'd1;
    localparam logic [1:0] REG_VBASE = 2'd2;
    localparam logic [1:0] REG_ISR   = 2'd3;

    localparam logic [3:0] SPURIOUS_LO = 4'hF;

    // Vector placed on the bus: even slot per source, 0xF slot when nothing
    // was requesting at acknowledge time.
    function automatic logic [7:0] make_vector(input logic [3:0] vbase_hi,
                                               input logic       valid,
                                               input logic [2:0] idx);
        logic [7:0] vec;
        if (valid) begin
            vec = {vbase_hi, idx, 1'b0};
        end else begin
            vec = {vbase_hi, SPURIOUS_LO};
        end
        return vec;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request bit is set and the
// index of the lowest set bit (bit 0 has the highest priority).
// Ports:
//   req_vec  in   8  request bits (already masked)
//   valid    out  1  at least one bit set
//   idx      out  3  index of the lowest set bit, 0 when none
module irq_prio_enc (
    input  logic [7:0] req_vec,
    output logic       valid,
    output logic [2:0] idx
);

    // Scan from the top down so the lowest set bit is the last one kept.
    always_comb begin
        valid = |req_vec;
        idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = req_vec[i] ? i[2:0] : idx;
        end
    end

endmodule

// File: rtl/irq_vectorer.sv
// Eight-input vectored interrupt controller.
// Falling edges on irqn latch into pending; pending & mask selects the
// lowest-numbered source, which pulls intn low. On the CPU acknowledge the
// vector {vbase[7:4], idx, 0} (or {vbase[7:4], 0xF} if the request vanished)
// is driven on the bus and the source moves to in_service until EOI.
// I/O window IO_BASE..IO_BASE+3: mask, pending/EOI, vbase, in_service.
// Ports:
//   gclk1   in   1  system clock
//   resetn  in   1  asynchronous active-low reset
//   irqn    in   8  interrupt requests, active low, asynchronous
//   A       in   8  CPU address (low byte)
//   d_in    in   8  CPU write data
//   d_out   out  8  read data / acknowledge vector
//   d_oe    out  1  data bus output enable
//   iorqn, m1n, rdn, wrn, intan  in  CPU bus control, active low
//   intn    out  1  interrupt request to the CPU, active low, registered
module irq_vectorer
    import irq_vectorer_pkg::*;
#(
    parameter logic [7:0] IO_BASE = 8'h18,
    parameter int         NUM_IRQ = 8
) (
    input  logic               gclk1,
    input  logic               resetn,
    input  logic [NUM_IRQ-1:0] irqn,
    input  logic [7:0]         A,
    input  logic [7:0]         d_in,
    output logic [7:0]         d_out,
    output logic               d_oe,
    input  logic               iorqn,
    input  logic               m1n,
    input  logic               rdn,
    input  logic               wrn,
    input  logic               intan,
    output logic               intn
);

    // Synchronisers: stage1, stage2 and a history stage for edge detection.
    logic [NUM_IRQ-1:0] irq_s1_q, irq_s1_d;
    logic [NUM_IRQ-1:0] irq_s2_q, irq_s2_d;
    logic [NUM_IRQ-1:0] irq_h_q, irq_h_d;
    logic [2:0]         wr_sync_q, wr_sync_d;   // {history, stage2, stage1}
    logic [2:0]         ia_sync_q, ia_sync_d;   // {history, stage2, stage1}

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] in_service_q, in_service_d;
    logic [3:0]         vbase_q, vbase_d;
    logic [7:0]         vec_q, vec_d;
    logic               spurious_q, spurious_d;
    logic               intn_q, intn_d;

    logic               sel;
    logic [NUM_IRQ-1:0] irq_fall;
    logic               wr_stb;
    logic               ia_fall;
    logic               eoi;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] req_masked;
    logic               req_valid;
    logic [2:0]         req_idx;
    logic [7:0]         rd_data;
    logic               vec_drive;

    // Register window decode; an acknowledge cycle never counts as an access.
    assign sel = ~iorqn & m1n & intan & (A[7:2] == IO_BASE[7:2]);

    assign irq_fall   = irq_h_q & ~irq_s2_q;
    assign wr_stb     = wr_sync_q[2] & ~wr_sync_q[1] & sel;
    assign ia_fall    = ia_sync_q[2] & ~ia_sync_q[1];
    assign req_masked = pending_q & mask_q;

    irq_prio_enc u_prio (
        .req_vec (req_masked),
        .valid   (req_valid),
        .idx     (req_idx)
    );

    // Next values of the synchroniser chains.
    always_comb begin
        irq_s1_d  = irqn;
        irq_s2_d  = irq_s1_q;
        irq_h_d   = irq_s2_q;
        wr_sync_d = {wr_sync_q[1:0], wrn};
        ia_sync_d = {ia_sync_q[1:0], intan};
    end

    // Register writes, controller next state and pending/in-service update.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        vbase_d    = vbase_q;
        vec_d      = vec_q;
        spurious_d = spurious_q;
        eoi        = 1'b0;
        ack_clr    = {NUM_IRQ{1'b0}};

        if (wr_stb) begin
            case (A[1:0])
                REG_MASK:  mask_d  = d_in[NUM_IRQ-1:0];
                REG_PEND:  eoi     = (state_q == WAIT_EOI);
                REG_VBASE: vbase_d = d_in[7:4];
                REG_ISR:   eoi     = 1'b0;
                default:   eoi     = 1'b0;
            endcase
        end else begin
            eoi = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d = req_valid ? REQ : IDLE;
            end
            REQ: begin
                // The winner is re-evaluated at acknowledge time; a mask write
                // since entering REQ can leave nothing to hand out.
                if (ia_fall) begin
                    vec_d      = make_vector(vbase_q, req_valid, req_idx);
                    spurious_d = ~req_valid;
                    ack_clr    = req_valid ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << req_idx)
                                           : {NUM_IRQ{1'b0}};
                    state_d    = ACK;
                end else begin
                    state_d = REQ;
                end
            end
            ACK: begin
                if (ia_sync_q[1]) begin
                    state_d = spurious_q ? IDLE : WAIT_EOI;
                end else begin
                    state_d = ACK;
                end
            end
            WAIT_EOI: begin
                state_d = eoi ? IDLE : WAIT_EOI;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new edge on the source being acknowledged survives the clear.
        pending_d    = (pending_q & ~ack_clr) | irq_fall;
        in_service_d = eoi ? {NUM_IRQ{1'b0}} : (in_service_q | ack_clr);
        intn_d       = (state_d != REQ);
    end

    // State registers; synchronisers idle high like the lines they follow.
    always_ff @(posedge gclk1 or negedge resetn) begin
        if (!resetn) begin
            irq_s1_q     <= {NUM_IRQ{1'b1}};
            irq_s2_q     <= {NUM_IRQ{1'b1}};
            irq_h_q      <= {NUM_IRQ{1'b1}};
            wr_sync_q    <= 3'b111;
            ia_sync_q    <= 3'b111;
            state_q      <= IDLE;
            mask_q       <= {NUM_IRQ{1'b0}};
            pending_q    <= {NUM_IRQ{1'b0}};
            in_service_q <= {NUM_IRQ{1'b0}};
            vbase_q      <= 4'h0;
            vec_q        <= 8'h00;
            spurious_q   <= 1'b0;
            intn_q       <= 1'b1;
        end else begin
            irq_s1_q     <= irq_s1_d;
            irq_s2_q     <= irq_s2_d;
            irq_h_q      <= irq_h_d;
            wr_sync_q    <= wr_sync_d;
            ia_sync_q    <= ia_sync_d;
            state_q      <= state_d;
            mask_q       <= mask_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            vbase_q      <= vbase_d;
            vec_q        <= vec_d;
            spurious_q   <= spurious_d;
            intn_q       <= intn_d;
        end
    end

    // Bus read mux; the vector follows the raw intan so it drops as soon as
    // the CPU ends the acknowledge cycle.
    always_comb begin
        case (A[1:0])
            REG_MASK:  rd_data = mask_q;
            REG_PEND:  rd_data = pending_q;
            REG_VBASE: rd_data = {vbase_q, 4'h0};
            REG_ISR:   rd_data = in_service_q;
            default:   rd_data = 8'h00;
        endcase

        vec_drive = (state_q == ACK) & ~intan;

        if (vec_drive) begin
            d_out = vec_q;
        end else if (sel) begin
            d_out = rd_data;
        end else begin
            d_out = 8'h00;
        end

        d_oe = resetn & (vec_drive | (sel & ~rdn));
    end

    assign intn = intn_q;

endmodule

// File: tb/tb_irq_vectorer.sv
// Randomised and directed checks of irq_vectorer against a transaction-level
// model: pending/mask/vbase/in_service bytes plus two flags recording whether
// intn has been raised and whether a source awaits EOI.
module tb_irq_vectorer;

    localparam logic [7:0] IO_A = 8'h18;

    logic       gclk1  = 1'b0;
    logic       resetn = 1'b1;
    logic [7:0] irqn   = 8'hFF;
    logic [7:0] A      = 8'h00;
    logic [7:0] d_in   = 8'h00;
    logic [7:0] d_out;
    logic       d_oe;
    logic       iorqn  = 1'b1;
    logic       m1n    = 1'b1;
    logic       rdn    = 1'b1;
    logic       wrn    = 1'b1;
    logic       intan  = 1'b1;
    logic       intn;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [7:0] m_mask, m_pend, m_vbase, m_isr;
    logic       m_wait_eoi, m_raised;
    logic [7:0] rv;
    logic [7:0] got;
    logic [7:0] exp_v;

    always #5 gclk1 = ~gclk1;

    irq_vectorer dut (
        .gclk1  (gclk1),
        .resetn (resetn),
        .irqn   (irqn),
        .A      (A),
        .d_in   (d_in),
        .d_out  (d_out),
        .d_oe   (d_oe),
        .iorqn  (iorqn),
        .m1n    (m1n),
        .rdn    (rdn),
        .wrn    (wrn),
        .intan  (intan),
        .intn   (intn)
    );

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge gclk1);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic void m_settle();
        if (!m_wait_eoi && !m_raised && ((m_pend & m_mask) != 8'h00)) m_raised = 1'b1;
    endfunction

    function automatic logic [7:0] m_ack();
        logic [7:0] act;
        act = m_pend & m_mask;
        m_raised = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (act[i]) begin
                m_pend[i]  = 1'b0;
                m_isr      = 8'h01 << i;
                m_wait_eoi = 1'b1;
                return {m_vbase[7:4], i[2:0], 1'b0};
            end
        end
        return {m_vbase[7:4], 4'hF};
    endfunction

    function automatic void m_write(input logic [1:0] off, input logic [7:0] data);
        case (off)
            2'd0: m_mask = data;
            2'd1: if (m_wait_eoi) begin m_isr = 8'h00; m_wait_eoi = 1'b0; end
            2'd2: m_vbase = data & 8'hF0;
            default: ;
        endcase
        m_settle();
    endfunction

    function automatic logic [7:0] m_read(input logic [1:0] off);
        case (off)
            2'd0:    return m_mask;
            2'd1:    return m_pend;
            2'd2:    return m_vbase;
            default: return m_isr;
        endcase
    endfunction

    // ---------------- bus operations ----------------
    task automatic check_intn(input string tag);
        check_eq(tag, {7'd0, intn}, {7'd0, ~m_raised});
    endtask

    task automatic read_check(input string tag, input logic [1:0] off, output logic [7:0] val);
        A = IO_A | {6'd0, off};
        iorqn = 1'b0;
        rdn = 1'b0;
        #1;
        val = d_out;
        check_eq(tag, d_out, m_read(off));
        check_eq({tag, "_oe"}, {7'd0, d_oe}, 8'h01);
        iorqn = 1'b1;
        rdn = 1'b1;
        #1;
    endtask

    task automatic io_write(input logic [1:0] off, input logic [7:0] data);
        A = IO_A | {6'd0, off};
        d_in = data;
        iorqn = 1'b0;
        wrn = 1'b0;
        repeat (4) tick();
        wrn = 1'b1;
        iorqn = 1'b1;
        repeat (3) tick();
        m_write(off, data);
    endtask

    task automatic pulse_irq(input logic [7:0] bits);
        irqn = ~bits;
        repeat (4) tick();
        m_pend = m_pend | bits;
        irqn = 8'hFF;
        repeat (3) tick();
        m_settle();
    endtask

    task automatic do_ack(input string tag, output logic [7:0] vec);
        logic [7:0] exp;
        check_intn({tag, "_intn_pre"});
        intan = 1'b0;
        repeat (4) tick();
        exp = m_ack();
        vec = d_out;
        check_eq({tag, "_vec"}, d_out, exp);
        check_eq({tag, "_oe"}, {7'd0, d_oe}, 8'h01);
        intan = 1'b1;
        #1;
        check_eq({tag, "_oe_rel"}, {7'd0, d_oe}, 8'h00);
        repeat (5) tick();
        m_settle();
    endtask

    task automatic hard_reset(input logic [7:0] lvl);
        irqn = lvl;
        resetn = 1'b0;
        #1;
        check_eq("rst_intn", {7'd0, intn}, 8'h01);
        check_eq("rst_doe", {7'd0, d_oe}, 8'h00);
        check_eq("rst_dout", d_out, 8'h00);
        intan = 1'b1;
        repeat (3) tick();
        resetn = 1'b1;
        m_mask = 8'h00; m_pend = 8'h00; m_vbase = 8'h00; m_isr = 8'h00;
        m_wait_eoi = 1'b0; m_raised = 1'b0;
        for (int off = 0; off < 4; off++) read_check("rst_reg", 2'(off), rv);
        repeat (4) tick();
        m_pend = ~lvl;
        m_settle();
        read_check("post_rst_pend", 2'd1, rv);
        check_intn("post_rst_intn");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();

        // Reset with every request line held low.
        hard_reset(8'h00);
        irqn = 8'hFF;
        repeat (3) tick();
        hard_reset(8'hFF);

        // Two sources, lower index wins; intn latency from the pin.
        io_write(2'd2, 8'h40);
        io_write(2'd0, 8'h28);
        irqn = ~8'h20;
        repeat (3) tick();
        check_eq("irq5_intn_3cyc", {7'd0, intn}, 8'h01);
        tick();
        check_eq("irq5_intn_4cyc", {7'd0, intn}, 8'h00);
        m_pend = m_pend | 8'h20;
        irqn = 8'hFF;
        repeat (3) tick();
        m_settle();
        pulse_irq(8'h08);
        do_ack("ack_irq3", got);
        check_eq("ack_irq3_const", got, 8'h46);
        read_check("pend_after_irq3", 2'd1, rv);
        read_check("isr_after_irq3", 2'd3, rv);

        // EOI: intn comes back one cycle after the write takes effect.
        A = IO_A | 8'h01;
        d_in = 8'h00;
        iorqn = 1'b0;
        wrn = 1'b0;
        repeat (3) tick();
        check_eq("eoi_intn_hold", {7'd0, intn}, 8'h01);
        tick();
        check_eq("eoi_intn_reassert", {7'd0, intn}, 8'h00);
        wrn = 1'b1;
        iorqn = 1'b1;
        repeat (3) tick();
        m_write(2'd1, 8'h00);
        do_ack("ack_irq5", got);
        check_eq("ack_irq5_const", got, 8'h4A);
        io_write(2'd1, 8'h00);

        // Mask removed between request and acknowledge: spurious vector.
        io_write(2'd0, 8'h01);
        pulse_irq(8'h01);
        check_intn("irq0_intn");
        io_write(2'd0, 8'h00);
        check_intn("masked_intn_held");
        do_ack("ack_spur", got);
        check_eq("ack_spur_const", got, 8'h4F);
        read_check("isr_after_spur", 2'd3, rv);
        check_intn("intn_after_spur");
        io_write(2'd0, 8'h01);
        check_intn("idle_after_spur");
        do_ack("ack_irq0", got);
        io_write(2'd1, 8'h00);

        // New edge on the very cycle the acknowledge clears that source.
        io_write(2'd0, 8'h04);
        pulse_irq(8'h04);
        check_intn("irq2_intn");
        irqn = ~8'h04;
        intan = 1'b0;
        repeat (4) tick();
        exp_v = m_ack();
        m_pend = m_pend | 8'h04;
        check_eq("same_cycle_vec", d_out, exp_v);
        intan = 1'b1;
        irqn = 8'hFF;
        repeat (5) tick();
        m_settle();
        read_check("same_cycle_pend", 2'd1, rv);
        check_eq("same_cycle_pend2", {7'd0, rv[2]}, 8'h01);
        io_write(2'd1, 8'h00);
        check_intn("same_cycle_reassert");

        // Reset in the middle of an acknowledge.
        intan = 1'b0;
        repeat (4) tick();
        check_eq("mid_ack_oe", {7'd0, d_oe}, 8'h01);
        hard_reset(8'hFF);

        // Randomised traffic.
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 5))
                0: pulse_irq(8'($urandom_range(0, 255)));
                1: io_write(2'd0, 8'($urandom_range(0, 255)));
                2: io_write(2'd2, 8'($urandom_range(0, 255)));
                3: begin
                    if (m_raised) do_ack("rnd_ack", got);
                    else io_write(2'd1, 8'($urandom_range(0, 255)));
                end
                4: begin
                    if (m_raised) do_ack("rnd_ack", got);
                    else io_write(2'($urandom_range(1, 3)), 8'($urandom_range(0, 255)));
                end
                default: read_check("rnd_read", 2'($urandom_range(0, 3)), rv);
            endcase
            check_intn("rnd_intn");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
